// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID register, one outstanding imem request, redirect squash and a one-entry stall hold buffer.
// Latency: response in cycle N appears on IF/ID in N+1; next request in N+1 (one instruction per two cycles at best).
// Backpressure: STALL freezes IF/ID; a response arriving under stall parks in the hold buffer until release.
module fetch_unit #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        PC_STEP  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REDIRECT,
  input  logic [ADDR_W-1:0] REDIRECT_PC,
  input  logic              STALL,
  output logic              IMEM_REQ,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic              IMEM_VALID,
  input  logic [DATA_W-1:0] IMEM_RDATA,
  output logic              IF_ID_VALID,
  output logic [ADDR_W-1:0] IF_ID_PC,
  output logic [ADDR_W-1:0] IF_ID_NEXT_PC,
  output logic [DATA_W-1:0] IF_ID_INST
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic                kill;
  logic [DATA_W-1:0]   hold_inst;
  logic [ADDR_W-1:0]   hold_pc;
  logic                if_id_valid;
  logic [ADDR_W-1:0]   if_id_pc;
  logic [ADDR_W-1:0]   if_id_next_pc;
  logic [DATA_W-1:0]   if_id_inst;

  // Fetch FSM, PC, kill flag, hold buffer and IF/ID register in one registered block
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_ISSUE;
      pc            <= RESET_PC;
      kill          <= 1'b0;
      hold_inst     <= '0;
      hold_pc       <= '0;
      if_id_valid   <= 1'b0;
      if_id_pc      <= '0;
      if_id_next_pc <= '0;
      if_id_inst    <= '0;
    end else begin
      // IF/ID default: redirect squashes even under stall; otherwise stall
      // holds everything and an idle cycle inserts a bubble. A new
      // instruction load below overrides this.
      if (REDIRECT || !STALL) begin
        if_id_valid <= 1'b0;
      end

      case (state)
        ST_ISSUE: begin
          // The request goes out this cycle regardless, so a redirect here
          // must still wait for (and discard) its response.
          state <= ST_WAIT;
          if (REDIRECT) begin
            pc   <= REDIRECT_PC;
            kill <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (IMEM_VALID) begin
            if (kill || REDIRECT) begin
              // Stale or squashed response: drop it and refetch from pc.
              kill  <= 1'b0;
              state <= ST_ISSUE;
              if (REDIRECT) begin
                pc <= REDIRECT_PC;
              end
            end else if (STALL) begin
              // Decode is busy: park the instruction until it frees up.
              hold_inst <= IMEM_RDATA;
              hold_pc   <= pc;
              state     <= ST_HOLD;
            end else begin
              if_id_valid   <= 1'b1;
              if_id_pc      <= pc;
              if_id_next_pc <= pc + STEP;
              if_id_inst    <= IMEM_RDATA;
              pc            <= pc + STEP;
              state         <= ST_ISSUE;
            end
          end else if (REDIRECT) begin
            // Response still in flight: mark it for discard on arrival.
            pc   <= REDIRECT_PC;
            kill <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (REDIRECT) begin
            // Parked instruction is on the wrong path; nothing is in flight.
            hold_inst <= '0;
            hold_pc   <= '0;
            pc        <= REDIRECT_PC;
            state     <= ST_ISSUE;
          end else if (!STALL) begin
            if_id_valid   <= 1'b1;
            if_id_pc      <= hold_pc;
            if_id_next_pc <= hold_pc + STEP;
            if_id_inst    <= hold_inst;
            pc            <= hold_pc + STEP;
            state         <= ST_ISSUE;
          end
        end

        default: begin
          state <= ST_ISSUE;
        end
      endcase
    end
  end

  // Memory request decoded purely from registered state and PC
  assign IMEM_REQ      = (state == ST_ISSUE);
  assign IMEM_ADDR     = pc;

  assign IF_ID_VALID   = if_id_valid;
  assign IF_ID_PC      = if_id_pc;
  assign IF_ID_NEXT_PC = if_id_next_pc;
  assign IF_ID_INST    = if_id_inst;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall/hold, redirect squash, 8-bit wrap, reset mid-request.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Two instances: 32-bit at RESET_PC=0x100 and 8-bit at RESET_PC=0xFC, sharing clock and reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_next_pc;
  logic [31:0] if_id_inst;

  logic        redirect8;
  logic [7:0]  redirect_pc8;
  logic        stall8;
  logic        imem_req8;
  logic [7:0]  imem_addr8;
  logic        imem_valid8;
  logic [31:0] imem_rdata8;
  logic        if_id_valid8;
  logic [7:0]  if_id_pc8;
  logic [7:0]  if_id_next_pc8;
  logic [31:0] if_id_inst8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h100), .PC_STEP(4)) dut (
    .CLK(clk), .RST(rst), .REDIRECT(redirect), .REDIRECT_PC(redirect_pc), .STALL(stall),
    .IMEM_REQ(imem_req), .IMEM_ADDR(imem_addr), .IMEM_VALID(imem_valid), .IMEM_RDATA(imem_rdata),
    .IF_ID_VALID(if_id_valid), .IF_ID_PC(if_id_pc), .IF_ID_NEXT_PC(if_id_next_pc), .IF_ID_INST(if_id_inst)
  );

  fetch_unit #(.ADDR_W(8), .DATA_W(32), .RESET_PC(8'hFC), .PC_STEP(4)) dut8 (
    .CLK(clk), .RST(rst), .REDIRECT(redirect8), .REDIRECT_PC(redirect_pc8), .STALL(stall8),
    .IMEM_REQ(imem_req8), .IMEM_ADDR(imem_addr8), .IMEM_VALID(imem_valid8), .IMEM_RDATA(imem_rdata8),
    .IF_ID_VALID(if_id_valid8), .IF_ID_PC(if_id_pc8), .IF_ID_NEXT_PC(if_id_next_pc8), .IF_ID_INST(if_id_inst8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    redirect8 = 1'b0; redirect_pc8 = '0; stall8 = 1'b0; imem_valid8 = 1'b0; imem_rdata8 = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", if_id_valid); end checks++;
    if (if_id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", if_id_pc); end checks++;
    if (if_id_next_pc !== 32'h0) begin errors++; $display("FAIL reset_next_pc got %h exp 0", if_id_next_pc); end checks++;
    if (if_id_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", if_id_inst); end checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got %h exp 1", imem_req); end checks++;
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL reset_addr got %h exp 100", imem_addr); end checks++;
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a = 32'h100 + 32'(4 * i);
      if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d] got %h exp 1", i, imem_req); end checks++;
      if (imem_addr !== a) begin errors++; $display("FAIL seq_addr[%0d] got %h exp %h", i, imem_addr, a); end checks++;
      step();
      if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_wait_req[%0d] got %h exp 0", i, imem_req); end checks++;
      if (if_id_valid !== 1'b0) begin errors++; $display("FAIL seq_bubble[%0d] got %h exp 0", i, if_id_valid); end checks++;
      imem_valid = 1'b1; imem_rdata = a ^ 32'hFFFF0000;
      step();
      imem_valid = 1'b0;
      if (if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %h exp 1", i, if_id_valid); end checks++;
      if (if_id_pc !== a) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, if_id_pc, a); end checks++;
      if (if_id_next_pc !== a + 32'h4) begin errors++; $display("FAIL seq_npc[%0d] got %h exp %h", i, if_id_next_pc, a + 32'h4); end checks++;
      if (if_id_inst !== (a ^ 32'hFFFF0000)) begin errors++; $display("FAIL seq_inst[%0d] got %h exp %h", i, if_id_inst, a ^ 32'hFFFF0000); end checks++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    step();                                   // WAIT for 0x100
    imem_valid = 1'b1; imem_rdata = 32'h11111111;
    step();                                   // IF/ID holds 0x100, ISSUE 0x104
    imem_valid = 1'b0;
    step();                                   // WAIT for 0x104, IF/ID bubble
    imem_valid = 1'b1; imem_rdata = 32'hDEADBEEF; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      imem_valid = 1'b0;
      if (i == 2) stall = 1'b0;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %h exp 0", i, imem_req); end checks++;
      if (if_id_pc !== 32'h100) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 100", i, if_id_pc); end checks++;
      if (if_id_inst !== 32'h11111111) begin errors++; $display("FAIL stall_inst[%0d] got %h exp 11111111", i, if_id_inst); end checks++;
      if (if_id_valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d] got %h exp 0", i, if_id_valid); end checks++;
    end
    step();
    if (if_id_valid !== 1'b1) begin errors++; $display("FAIL release_valid got %h exp 1", if_id_valid); end checks++;
    if (if_id_pc !== 32'h104) begin errors++; $display("FAIL release_pc got %h exp 104", if_id_pc); end checks++;
    if (if_id_next_pc !== 32'h108) begin errors++; $display("FAIL release_npc got %h exp 108", if_id_next_pc); end checks++;
    if (if_id_inst !== 32'hDEADBEEF) begin errors++; $display("FAIL release_inst got %h exp deadbeef", if_id_inst); end checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL release_req got %h exp 1", imem_req); end checks++;
    if (imem_addr !== 32'h108) begin errors++; $display("FAIL release_addr got %h exp 108", imem_addr); end checks++;
  endtask

  task automatic test_redirect_wait();
    do_reset();
    step();                                   // W1: request for 0x100 in flight
    redirect = 1'b1; redirect_pc = 32'h400;
    step();                                   // W2
    redirect = 1'b0;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_w2_req got %h exp 0", imem_req); end checks++;
    if (if_id_valid !== 1'b0) begin errors++; $display("FAIL redir_w2_valid got %h exp 0", if_id_valid); end checks++;
    step();                                   // W3: late response arrives
    if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_w3_req got %h exp 0", imem_req); end checks++;
    imem_valid = 1'b1; imem_rdata = 32'hBADBAD00;
    step();
    imem_valid = 1'b0;
    if (if_id_valid !== 1'b0) begin errors++; $display("FAIL redir_drop_valid got %h exp 0", if_id_valid); end checks++;
    if (if_id_inst !== 32'h0) begin errors++; $display("FAIL redir_drop_inst got %h exp 0", if_id_inst); end checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL redir_req got %h exp 1", imem_req); end checks++;
    if (imem_addr !== 32'h400) begin errors++; $display("FAIL redir_addr got %h exp 400", imem_addr); end checks++;
    step();
    imem_valid = 1'b1; imem_rdata = 32'h0400AAAA;
    step();
    imem_valid = 1'b0;
    if (if_id_valid !== 1'b1) begin errors++; $display("FAIL redir_fetch_valid got %h exp 1", if_id_valid); end checks++;
    if (if_id_pc !== 32'h400) begin errors++; $display("FAIL redir_fetch_pc got %h exp 400", if_id_pc); end checks++;
    if (if_id_inst !== 32'h0400AAAA) begin errors++; $display("FAIL redir_fetch_inst got %h exp 0400aaaa", if_id_inst); end checks++;
  endtask

  task automatic test_redirect_collide();
    do_reset();
    step();
    imem_valid = 1'b1; imem_rdata = 32'h55550100;
    step();                                   // IF/ID valid 0x100, ISSUE 0x104
    imem_valid = 1'b0; stall = 1'b1;
    step();                                   // WAIT, IF/ID held under stall
    if (if_id_valid !== 1'b1) begin errors++; $display("FAIL coll_held_valid got %h exp 1", if_id_valid); end checks++;
    imem_valid = 1'b1; imem_rdata = 32'h99999999; redirect = 1'b1; redirect_pc = 32'h400;
    step();
    imem_valid = 1'b0; redirect = 1'b0;
    if (if_id_valid !== 1'b0) begin errors++; $display("FAIL coll_valid got %h exp 0", if_id_valid); end checks++;
    if (if_id_inst !== 32'h55550100) begin errors++; $display("FAIL coll_inst got %h exp 55550100", if_id_inst); end checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL coll_req got %h exp 1", imem_req); end checks++;
    if (imem_addr !== 32'h400) begin errors++; $display("FAIL coll_addr got %h exp 400", imem_addr); end checks++;
    // Response for 0x400 parks in the hold buffer, then a redirect drops it.
    step();
    imem_valid = 1'b1; imem_rdata = 32'h04040404;
    step();                                   // HOLD
    imem_valid = 1'b0; redirect = 1'b1; redirect_pc = 32'h800;
    step();
    redirect = 1'b0; stall = 1'b0;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL hold_redir_req got %h exp 1", imem_req); end checks++;
    if (imem_addr !== 32'h800) begin errors++; $display("FAIL hold_redir_addr got %h exp 800", imem_addr); end checks++;
    step();
    if (if_id_valid !== 1'b0) begin errors++; $display("FAIL hold_redir_valid got %h exp 0", if_id_valid); end checks++;
  endtask

  task automatic test_wrap();
    do_reset();
    if (imem_req8 !== 1'b1) begin errors++; $display("FAIL wrap_req0 got %h exp 1", imem_req8); end checks++;
    if (imem_addr8 !== 8'hFC) begin errors++; $display("FAIL wrap_addr0 got %h exp fc", imem_addr8); end checks++;
    step();
    imem_valid8 = 1'b1; imem_rdata8 = 32'hCAFE00FC;
    step();
    imem_valid8 = 1'b0;
    if (if_id_pc8 !== 8'hFC) begin errors++; $display("FAIL wrap_pc got %h exp fc", if_id_pc8); end checks++;
    if (if_id_next_pc8 !== 8'h00) begin errors++; $display("FAIL wrap_npc got %h exp 00", if_id_next_pc8); end checks++;
    if (if_id_inst8 !== 32'hCAFE00FC) begin errors++; $display("FAIL wrap_inst got %h exp cafe00fc", if_id_inst8); end checks++;
    if (imem_addr8 !== 8'h00) begin errors++; $display("FAIL wrap_addr1 got %h exp 00", imem_addr8); end checks++;
    step();
    imem_valid8 = 1'b1; imem_rdata8 = 32'h12340000;
    step();
    imem_valid8 = 1'b0;
    if (if_id_pc8 !== 8'h00) begin errors++; $display("FAIL wrap_pc1 got %h exp 00", if_id_pc8); end checks++;
    if (if_id_next_pc8 !== 8'h04) begin errors++; $display("FAIL wrap_npc1 got %h exp 04", if_id_next_pc8); end checks++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    step();
    imem_valid = 1'b1; imem_rdata = 32'h55550100;
    step();                                   // IF/ID loaded, ISSUE 0x104
    imem_valid = 1'b0;
    step();                                   // WAIT for 0x104
    rst = 1'b1;
    step();                                   // reset taken, response arrives next
    rst = 1'b0; imem_valid = 1'b1; imem_rdata = 32'hEEEEEEEE;
    if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %h exp 0", if_id_valid); end checks++;
    if (if_id_pc !== 32'h0) begin errors++; $display("FAIL rmid_pc got %h exp 0", if_id_pc); end checks++;
    if (if_id_inst !== 32'h0) begin errors++; $display("FAIL rmid_inst got %h exp 0", if_id_inst); end checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL rmid_req got %h exp 1", imem_req); end checks++;
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL rmid_addr got %h exp 100", imem_addr); end checks++;
    step();
    imem_valid = 1'b0;
    if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rmid_ignored_valid got %h exp 0", if_id_valid); end checks++;
    if (if_id_inst !== 32'h0) begin errors++; $display("FAIL rmid_ignored_inst got %h exp 0", if_id_inst); end checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rmid_wait_req got %h exp 0", imem_req); end checks++;
    imem_valid = 1'b1; imem_rdata = 32'h00000007;
    step();
    imem_valid = 1'b0;
    if (if_id_pc !== 32'h100) begin errors++; $display("FAIL rmid_fetch_pc got %h exp 100", if_id_pc); end checks++;
    if (if_id_inst !== 32'h7) begin errors++; $display("FAIL rmid_fetch_inst got %h exp 7", if_id_inst); end checks++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_collide();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
